// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tile chain: control broadcast, tap ripple bus
// and tile-to-tile sample/psum link.
package fir_pkg;

    localparam int SHIFT_W       = 5;
    localparam int TAPS_PER_TILE = 8;

    localparam logic [1:0] FLUSH_NONE = 2'd0;
    localparam logic [1:0] FLUSH_PSUM = 2'd1;
    localparam logic [1:0] FLUSH_TAPS = 2'd2;

    typedef logic [31:0] DATA_SAMPLE;

    typedef struct packed {
        logic [1:0]         flush;
        logic               enable;
        logic               is_auto;
        logic [SHIFT_W-1:0] shift;
    } CONT_TO_TILE;

    typedef struct packed {
        logic       valid;
        DATA_SAMPLE data;
    } DATA_BUS;

    typedef struct packed {
        logic       valid;
        DATA_SAMPLE input_sample;
        DATA_SAMPLE psum;
    } TILE_TO_TILE;

    // Host tap count is forced into 1..cap so the load phase always has a coefficient window.
    function automatic logic [15:0] clamp_taps(input logic [15:0] n, input logic [15:0] cap);
        logic [15:0] r;
        r = n;
        if (n == 16'd0) r = 16'd1;
        else if (n > cap) r = cap;
        return r;
    endfunction

endpackage

// File: rtl/fir_ctrl_cnt.sv
// Loadable down-counter with zero flag; the sequencer time-shares one instance across
// the load, settle and drain phases.
module fir_ctrl_cnt #(
    parameter int W = 6
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic [W-1:0] count,
    output logic         zero
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = load_val;
        else if (dec && (count_q != '0))
            count_d = count_q - W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) count_q <= '0;
        else     count_q <= count_d;
    end

    assign count = count_q;
    assign zero  = (count_q == '0);

endmodule

// File: rtl/fir_chain_ctrl.sv
// Sequencer for the FIR tile chain: clears taps, ripples the tap words into the tail tile,
// settles, streams samples into the head tile and drains the psum pipeline.
//
// state    | meaning
// ---------+-----------------------------------------------------------------
// S_IDLE   | waiting for cfg_start
// S_CLR    | one cycle of flush=TAPS; returns to IDLE when entered by abort
// S_LOAD   | emit CAP tap words: host coefficients first, then zero padding
// S_SETTLE | NUM_TILES cycles of flush=PSUM while the tap ripple completes
// S_RUN    | enable=1, accept samples and forward them to tile 0
// S_DRAIN  | DRAIN_CYC cycles of enable=1 with no input, then done pulse
module fir_chain_ctrl
    import fir_pkg::*;
#(
    parameter int NUM_TILES = 4,
    parameter int DRAIN_CYC = NUM_TILES * 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_start,
    input  logic               cfg_abort,
    input  logic [15:0]        cfg_num_taps,
    input  logic [31:0]        cfg_num_samples,
    input  logic               cfg_is_auto,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               coef_valid,
    output logic               coef_ready,
    input  logic [31:0]        coef_data,
    input  logic               samp_valid,
    output logic               samp_ready,
    input  logic [31:0]        samp_data,
    output CONT_TO_TILE        cont_to_tile,
    output DATA_BUS            tap_bus,
    output TILE_TO_TILE        head_tile,
    output logic               busy,
    output logic               done
);

    localparam int CAP     = NUM_TILES * TAPS_PER_TILE;
    localparam int CNT_MAX = (DRAIN_CYC > CAP) ? DRAIN_CYC : CAP;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [15:0] CAP16 = 16'(CAP);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_SETTLE,
        S_RUN,
        S_DRAIN
    } state_t;

    state_t             state_q, state_d;
    logic               abort_q, abort_d;
    logic [15:0]        ntaps_q, ntaps_d;
    logic [31:0]        nsamp_q, nsamp_d;
    logic [31:0]        samp_cnt_q, samp_cnt_d;
    logic               is_auto_q, is_auto_d;
    logic [SHIFT_W-1:0] shift_q, shift_d;
    logic               coef_ready_q, coef_ready_d;
    logic               samp_ready_q, samp_ready_d;
    DATA_BUS            tap_q, tap_d;
    TILE_TO_TILE        head_q, head_d;
    logic [1:0]         flush_q, flush_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;

    logic               cnt_load, cnt_dec, cnt_zero, cnt_last;
    logic [CNT_W-1:0]   cnt_load_val, cnt_val, rem_next;
    logic               coef_hs, samp_hs, pad;

    fir_ctrl_cnt #(.W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .count    (cnt_val),
        .zero     (cnt_zero)
    );

    assign cnt_last = (cnt_val == CNT_W'(1));
    assign coef_hs  = coef_valid && coef_ready_q;
    assign samp_hs  = samp_valid && samp_ready_q;
    // In LOAD the counter holds the words still to send, so k >= num_taps maps to this compare.
    assign pad      = (16'(cnt_val) <= (CAP16 - ntaps_q));

    always_comb begin
        state_d      = state_q;
        abort_d      = abort_q;
        ntaps_d      = ntaps_q;
        nsamp_d      = nsamp_q;
        samp_cnt_d   = samp_cnt_q;
        is_auto_d    = is_auto_q;
        shift_d      = shift_q;
        tap_d        = '0;
        head_d       = '0;
        done_d       = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (cfg_start) begin
                    state_d    = S_CLR;
                    abort_d    = 1'b0;
                    ntaps_d    = clamp_taps(cfg_num_taps, CAP16);
                    nsamp_d    = cfg_num_samples;
                    is_auto_d  = cfg_is_auto;
                    shift_d    = cfg_shift;
                    samp_cnt_d = '0;
                end
            end
            S_CLR: begin
                if (abort_q) begin
                    state_d = S_IDLE;
                    abort_d = 1'b0;
                end else begin
                    state_d      = S_LOAD;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(CAP);
                end
            end
            S_LOAD: begin
                if (pad || coef_hs) begin
                    tap_d.valid = 1'b1;
                    tap_d.data  = pad ? '0 : coef_data;
                    cnt_dec     = 1'b1;
                    if (cnt_last) begin
                        state_d      = S_SETTLE;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(NUM_TILES);
                    end
                end
            end
            S_SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_last) state_d = S_RUN;
            end
            S_RUN: begin
                if (samp_hs) begin
                    head_d.valid        = 1'b1;
                    head_d.input_sample = samp_data;
                    samp_cnt_d          = samp_cnt_q + 32'd1;
                    if ((nsamp_q != '0) && (samp_cnt_d == nsamp_q)) begin
                        state_d      = S_DRAIN;
                        cnt_load     = 1'b1;
                        cnt_load_val = CNT_W'(DRAIN_CYC);
                    end
                end
            end
            S_DRAIN: begin
                cnt_dec = 1'b1;
                if (cnt_last) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Abort overrides everything, including a handshake accepted in the same cycle.
        if ((state_q != S_IDLE) && cfg_abort) begin
            state_d    = S_CLR;
            abort_d    = 1'b1;
            tap_d      = '0;
            head_d     = '0;
            done_d     = 1'b0;
            cnt_load   = 1'b0;
            cnt_dec    = 1'b0;
            samp_cnt_d = samp_cnt_q;
        end

        if (cnt_load)
            rem_next = cnt_load_val;
        else if (cnt_dec && !cnt_zero)
            rem_next = cnt_val - CNT_W'(1);
        else
            rem_next = cnt_val;

        coef_ready_d = (state_d == S_LOAD) && (16'(rem_next) > (CAP16 - ntaps_q));
        samp_ready_d = (state_d == S_RUN);
        enable_d     = (state_d == S_RUN) || (state_d == S_DRAIN);
        busy_d       = (state_d != S_IDLE);
        if (state_d == S_CLR)         flush_d = FLUSH_TAPS;
        else if (state_d == S_SETTLE) flush_d = FLUSH_PSUM;
        else                          flush_d = FLUSH_NONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            abort_q      <= 1'b0;
            ntaps_q      <= '0;
            nsamp_q      <= '0;
            samp_cnt_q   <= '0;
            is_auto_q    <= 1'b0;
            shift_q      <= '0;
            coef_ready_q <= 1'b0;
            samp_ready_q <= 1'b0;
            tap_q        <= '0;
            head_q       <= '0;
            flush_q      <= FLUSH_NONE;
            enable_q     <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            abort_q      <= abort_d;
            ntaps_q      <= ntaps_d;
            nsamp_q      <= nsamp_d;
            samp_cnt_q   <= samp_cnt_d;
            is_auto_q    <= is_auto_d;
            shift_q      <= shift_d;
            coef_ready_q <= coef_ready_d;
            samp_ready_q <= samp_ready_d;
            tap_q        <= tap_d;
            head_q       <= head_d;
            flush_q      <= flush_d;
            enable_q     <= enable_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign cont_to_tile = {flush_q, enable_q, is_auto_q, shift_q};
    assign tap_bus      = tap_q;
    assign head_tile    = head_q;
    assign coef_ready   = coef_ready_q;
    assign samp_ready   = samp_ready_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_fir_chain_ctrl.sv
// Directed bench for fir_chain_ctrl: load/pad sequencing, backpressure, run/drain,
// abort, reset and an impulse run through a behavioural tile-chain model.
module tb_fir_chain_ctrl;
    import fir_pkg::*;

    localparam int NT    = 4;
    localparam int CAP   = NT * 8;
    localparam int DRAIN = NT * 9;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_start, cfg_abort, cfg_is_auto;
    logic [15:0]        cfg_num_taps;
    logic [31:0]        cfg_num_samples;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               coef_valid, coef_ready, samp_valid, samp_ready;
    logic [31:0]        coef_data, samp_data;
    CONT_TO_TILE        cont_to_tile;
    DATA_BUS            tap_bus;
    TILE_TO_TILE        head_tile;
    logic               busy, done;

    fir_chain_ctrl #(.NUM_TILES(NT), .DRAIN_CYC(DRAIN)) dut (
        .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_abort(cfg_abort),
        .cfg_num_taps(cfg_num_taps), .cfg_num_samples(cfg_num_samples),
        .cfg_is_auto(cfg_is_auto), .cfg_shift(cfg_shift),
        .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
        .samp_valid(samp_valid), .samp_ready(samp_ready), .samp_data(samp_data),
        .cont_to_tile(cont_to_tile), .tap_bus(tap_bus), .head_tile(head_tile),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] words [CAP];
    int          nwords, load_cycles;
    logic [31:0] heads [64];
    int          nheads, n_done, drain_cycles;
    logic        busy_at_done;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_coefs(input int neff, input bit toggle, input logic [31:0] base);
        int  idx;
        bit  hs;
        idx = 0; nwords = 0; load_cycles = 0;
        for (int cyc = 0; cyc < 200 && nwords < CAP; cyc++) begin
            coef_valid = (idx < neff) && (!toggle || (cyc % 2 == 0));
            coef_data  = coef_valid ? base + 32'(idx) : 32'hDEAD_BEEF;
            hs = coef_valid && coef_ready;
            tick();
            load_cycles++;
            if (hs) idx++;
            if (tap_bus.valid) begin
                words[nwords] = tap_bus.data;
                nwords++;
            end
        end
        coef_valid = 1'b0;
        check("load_word_count", 64'(nwords), 64'(CAP));
        for (int k = 0; k < CAP; k++)
            check($sformatf("load_word%0d", k), 64'(words[k]),
                  (k < neff) ? 64'(base + 32'(k)) : 64'(0));
    endtask

    task automatic check_settle();
        for (int i = 0; i < NT; i++) begin
            check($sformatf("settle_flush%0d", i), 64'(cont_to_tile.flush), 64'(FLUSH_PSUM));
            if (i < NT - 1) tick();
        end
        tick();
        check("run_enable", 64'(cont_to_tile.enable), 64'(1));
        check("run_flush", 64'(cont_to_tile.flush), 64'(FLUSH_NONE));
        check("run_samp_ready", 64'(samp_ready), 64'(1));
    endtask

    task automatic run_capture(input int n_ticks, input logic [31:0] base, input bit impulse);
        int sidx;
        bit hs;
        sidx = 0; nheads = 0; n_done = 0; drain_cycles = 0; busy_at_done = 1'b1;
        for (int cyc = 0; cyc < n_ticks; cyc++) begin
            samp_valid = 1'b1;
            samp_data  = impulse ? ((sidx == 0) ? 32'd1 : 32'd0) : base + 32'(sidx);
            hs = samp_valid && samp_ready;
            tick();
            if (hs) sidx++;
            if (head_tile.valid && nheads < 64) begin
                heads[nheads] = head_tile.input_sample;
                nheads++;
            end
            if (done) begin
                n_done++;
                busy_at_done = busy;
            end
            if (cont_to_tile.enable && !samp_ready && busy) drain_cycles++;
        end
        samp_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] tile_buf [NT][8];
        logic [31:0] h [CAP];
        logic [31:0] acc;
        int          f2, hv, dn;

        rst = 1'b1; cfg_start = 0; cfg_abort = 0; cfg_is_auto = 0; cfg_num_taps = '0;
        cfg_num_samples = '0; cfg_shift = '0; coef_valid = 0; coef_data = '0;
        samp_valid = 0; samp_data = '0;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_cont", 64'(cont_to_tile), 64'(0));
        check("rst_tap", 64'(tap_bus), 64'(0));
        check("rst_head_valid", 64'(head_tile.valid), 64'(0));
        check("rst_readies", 64'({coef_ready, samp_ready, done}), 64'(0));

        // Job 1: 5 taps, 10 samples, steady valids
        cfg_num_taps = 16'd5; cfg_num_samples = 32'd10; cfg_is_auto = 1'b1; cfg_shift = 5'd3;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("j1_clr_flush", 64'(cont_to_tile.flush), 64'(FLUSH_TAPS));
        check("j1_clr_busy", 64'(busy), 64'(1));
        check("j1_is_auto", 64'(cont_to_tile.is_auto), 64'(1));
        check("j1_shift", 64'(cont_to_tile.shift), 64'(3));
        check("j1_clr_enable", 64'(cont_to_tile.enable), 64'(0));
        tick();
        check("j1_load_flush", 64'(cont_to_tile.flush), 64'(FLUSH_NONE));
        check("j1_load_ready", 64'(coef_ready), 64'(1));
        load_coefs(5, 1'b0, 32'd1);
        check("j1_load_cycles", 64'(load_cycles), 64'(32));
        check_settle();
        run_capture(70, 32'd100, 1'b0);
        check("j1_head_count", 64'(nheads), 64'(10));
        for (int i = 0; i < 10; i++)
            check($sformatf("j1_head%0d", i), 64'(heads[i]), 64'(100 + i));
        check("j1_done_pulses", 64'(n_done), 64'(1));
        check("j1_busy_at_done", 64'(busy_at_done), 64'(0));
        check("j1_drain_cycles", 64'(drain_cycles), 64'(DRAIN));
        check("j1_idle_busy", 64'(busy), 64'(0));

        // Job 2: coefficient backpressure, then abort in the 3rd RUN cycle
        cfg_num_taps = 16'd6; cfg_num_samples = 32'd0; cfg_is_auto = 1'b0; cfg_shift = 5'd17;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        check("j2_clr_flush", 64'(cont_to_tile.flush), 64'(FLUSH_TAPS));
        check("j2_shift", 64'(cont_to_tile.shift), 64'(17));
        tick();
        load_coefs(6, 1'b1, 32'hA0);
        check("j2_load_cycles", 64'(load_cycles), 64'(37));
        check_settle();
        samp_valid = 1'b1; samp_data = 32'd200;
        tick();
        check("j2_head0", 64'(head_tile), 64'({1'b1, 32'd200, 32'd0}));
        samp_data = 32'd201;
        tick();
        check("j2_head1", 64'(head_tile), 64'({1'b1, 32'd201, 32'd0}));
        samp_data = 32'd202; cfg_abort = 1'b1;
        tick();
        cfg_abort = 1'b0;
        check("j2_abort_head", 64'(head_tile.valid), 64'(0));
        check("j2_abort_flush", 64'(cont_to_tile.flush), 64'(FLUSH_TAPS));
        check("j2_abort_enable", 64'(cont_to_tile.enable), 64'(0));
        check("j2_abort_ready", 64'({coef_ready, samp_ready}), 64'(0));
        f2 = 0; hv = 0; dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (cont_to_tile.flush == FLUSH_TAPS) f2++;
            if (head_tile.valid) hv++;
            if (done) dn++;
        end
        samp_valid = 1'b0;
        check("j2_extra_clr", 64'(f2), 64'(0));
        check("j2_extra_head", 64'(hv), 64'(0));
        check("j2_abort_done", 64'(dn), 64'(0));
        check("j2_abort_idle", 64'(busy), 64'(0));

        // Job 3: start+abort together, num_taps=0 -> 1, reset mid-RUN
        cfg_num_taps = 16'd0; cfg_num_samples = 32'd0;
        cfg_start = 1'b1; cfg_abort = 1'b1;
        tick();
        cfg_start = 1'b0; cfg_abort = 1'b0;
        check("j3_start_busy", 64'(busy), 64'(1));
        check("j3_start_flush", 64'(cont_to_tile.flush), 64'(FLUSH_TAPS));
        tick();
        check("j3_in_load", 64'({busy, coef_ready, cont_to_tile.flush}), 64'({1'b1, 1'b1, 2'd0}));
        load_coefs(1, 1'b0, 32'h55);
        check_settle();
        samp_valid = 1'b1; samp_data = 32'd7;
        tick(); tick();
        check("j3_run_head", 64'(head_tile.valid), 64'(1));
        rst = 1'b1;
        tick(); tick(); tick();
        rst = 1'b0;
        tick();
        check("j3_rst_busy", 64'(busy), 64'(0));
        check("j3_rst_cont", 64'(cont_to_tile), 64'(0));
        check("j3_rst_head", 64'(head_tile), 64'(0));
        check("j3_rst_tap", 64'(tap_bus), 64'(0));
        check("j3_rst_misc", 64'({coef_ready, samp_ready, done}), 64'(0));
        samp_valid = 1'b0;

        // Job 4: 8 taps, impulse input through a behavioural tile chain
        cfg_num_taps = 16'd8; cfg_num_samples = 32'd12;
        cfg_start = 1'b1;
        tick();
        cfg_start = 1'b0;
        tick();
        load_coefs(8, 1'b0, 32'h11);
        for (int k = 0; k < CAP; k++) tile_buf[NT - 1 - k / 8][k % 8] = words[k];
        for (int j = 0; j < CAP; j++) h[j] = tile_buf[NT - 1 - j / 8][j % 8];
        check_settle();
        run_capture(70, 32'd0, 1'b1);
        check("j4_head_count", 64'(nheads), 64'(12));
        check("j4_done_pulses", 64'(n_done), 64'(1));
        for (int n = 0; n < 12; n++) begin
            acc = '0;
            for (int j = 0; j <= n; j++) acc = acc + h[j] * heads[n - j];
            check($sformatf("j4_psum%0d", n), 64'(acc), (n < 8) ? 64'(32'h11 + n) : 64'(0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
